// File: rtl/stage5_writeback_pkg.sv
// Shared definitions for the writeback stage: the FSM state encoding, the
// decoded-instruction fields this stage consumes, the RV32 opcodes and load
// funct3 encodings, and the rd_writes() helper.
package stage5_writeback_pkg;

  localparam int XLEN           = 32;
  localparam int REGISTER_WIDTH = XLEN;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no instruction in the stage register
    FRESH = 2'd1,  // load data is on the memory bus this cycle
    HELD  = 2'd2   // load data was captured into data_q
  } wb_state_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
  } decoded_instr_t;

  // Opcodes that architecturally write rd.
  function automatic logic rd_writes(input logic [6:0] opcode);
    case (opcode)
      OPCODE_LOAD, OPCODE_OP, OPCODE_OP_IMM, OPCODE_LUI,
      OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR: rd_writes = 1'b1;
      default:                               rd_writes = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/stage5_writeback_load_extract.sv
// load_extract: combinational sub-word load extraction.
//   funct3_i     load width/sign encoding
//   offset_i     byte offset of the effective address (addr[1:0])
//   word_i       aligned 32-bit word returned by the SRAM
//   value_o      extracted, sign/zero-extended value
//   misaligned_o halfword at odd offset, or word at nonzero offset
module load_extract
  import stage5_writeback_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] value_o,
  output logic            misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    value_o      = word_i;
    misaligned_o = 1'b0;
    case (funct3_i)
      F3_LB:  value_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: value_o = {24'd0, byte_sel};
      F3_LH: begin
        value_o      = {{16{half_sel[15]}}, half_sel};
        misaligned_o = offset_i[0];
      end
      F3_LHU: begin
        value_o      = {16'd0, half_sel};
        misaligned_o = offset_i[0];
      end
      // LW and any unlisted encoding are treated as a full-word access.
      default: misaligned_o = (offset_i != 2'd0);
    endcase
  end

endmodule

// File: rtl/stage5_writeback.sv
// stage5_writeback: final pipeline stage. Holds one instruction from the
// memory stage, merges synchronous-SRAM load data (valid only the cycle after
// acceptance), and drives the register-file write port. A hold request
// freezes retirement; if it arrives while the load data is still on the bus,
// the word is captured into data_q so it is never re-sampled.
//   clk_i, rst_i                clock, synchronous active-high reset
//   axis_*_i / axis_tready_o    beat from the memory stage
//   hold_i                      freeze retirement
//   rd_write_enable_o, rd_address_o, rd_write_data_o   regfile write port
//   retire_valid_o, misaligned_load_o                   per-retire pulses
//   pending_valid_o, pending_rd_o                       to hazard unit
//   instret_o                   retired-instruction count
module stage5_writeback
  import stage5_writeback_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            axis_tvalid_i,
  output logic            axis_tready_o,
  input  decoded_instr_t  axis_decoded_instruction_i,
  input  logic [XLEN-1:0] axis_alu_result_i,
  input  logic [XLEN-1:0] axis_data_from_memory_i,
  input  logic            hold_i,
  output logic            rd_write_enable_o,
  output logic [4:0]      rd_address_o,
  output logic [XLEN-1:0] rd_write_data_o,
  output logic            retire_valid_o,
  output logic            misaligned_load_o,
  output logic            pending_valid_o,
  output logic [4:0]      pending_rd_o,
  output logic [63:0]     instret_o
);

  wb_state_t       state_q;
  decoded_instr_t  instr_q;
  logic [XLEN-1:0] addr_q;    // alu_result: effective address or pc+4
  logic [XLEN-1:0] data_q;
  logic [63:0]     instret_q, instret_d;

  logic            accept, active, retire, is_load, writes_rd;
  logic [XLEN-1:0] load_word, load_value;
  logic            load_mis;

  assign active    = (state_q != EMPTY);
  assign retire    = active && !hold_i && !rst_i;
  assign accept    = axis_tvalid_i && axis_tready_o;
  assign instret_d = instret_q + 64'd1;
  assign is_load   = (instr_q.opcode == OPCODE_LOAD);
  assign writes_rd = rd_writes(instr_q.opcode) && (instr_q.rd != 5'd0);

  // In FRESH the SRAM result is on the bus regardless of tvalid.
  assign load_word = (state_q == FRESH) ? axis_data_from_memory_i : data_q;

  load_extract u_load_extract (
    .funct3_i     (instr_q.funct3),
    .offset_i     (addr_q[1:0]),
    .word_i       (load_word),
    .value_o      (load_value),
    .misaligned_o (load_mis)
  );

  // Retire and accept can coincide, so tready only drops while frozen.
  assign axis_tready_o     = (state_q == EMPTY) || !hold_i;
  assign retire_valid_o    = retire;
  assign misaligned_load_o = retire && is_load && load_mis;
  assign rd_write_enable_o = retire && writes_rd && !(is_load && load_mis);
  assign rd_address_o      = instr_q.rd;
  assign rd_write_data_o   = is_load ? load_value : addr_q;
  assign pending_valid_o   = active && writes_rd;
  assign pending_rd_o      = pending_valid_o ? instr_q.rd : 5'd0;
  assign instret_o         = instret_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= EMPTY;
      instr_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      instret_q <= '0;
    end else begin
      if (accept) begin
        instr_q <= axis_decoded_instruction_i;
        addr_q  <= axis_alu_result_i;
      end
      if (retire) instret_q <= instret_d;
      case (state_q)
        EMPTY: if (accept) state_q <= FRESH;
        FRESH, HELD: begin
          if (!hold_i) begin
            state_q <= accept ? FRESH : EMPTY;
          end else if (state_q == FRESH) begin
            // Last cycle the SRAM word is valid; keep it for the release.
            data_q  <= axis_data_from_memory_i;
            state_q <= HELD;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: doc/stage5_writeback.md
# stage5_writeback

Final pipeline stage: consumes beats from the memory stage, merges synchronous-SRAM load data with the instruction, sign/zero-extends sub-word loads, and drives the register-file write port. A single-entry holding register plus a 3-state FSM lets a halt (`hold`) freeze retirement without losing SRAM read data, which is valid only in the cycle after acceptance. Also maintains the retired-instruction counter and exposes pending-write information to the hazard unit.

## Interface
- `XLEN`, 32, register width (equals `REGISTER_WIDTH`)
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `axis_memory_to_writeback`  Axis.in  —  fields `decoded_instruction`, `alu_result`, `branch_target`, `data_from_memory`; `tready` driven here
- `hold`  in  1  freeze retirement (debug halt / external stall)
- `rd_write_enable`  out  1  register-file write strobe
- `rd_address`  out  5  destination register
- `rd_write_data`  out  XLEN  write value
- `retire_valid`  out  1  one pulse per retired instruction
- `misaligned_load`  out  1  pulse when a retiring load is misaligned
- `pending_valid`  out  1  stage register holds an unretired rd-writing instruction
- `pending_rd`  out  5  its rd
- `instret`  out  64  retired-instruction count

## Operation
- Execute stage places effective address in `alu_result` for loads/stores and pc+4 for JAL/JALR.
- FSM: EMPTY, FRESH (load data on bus this cycle), HELD (load data captured in `data_q`).
- `tready` = (state==EMPTY) || !hold. Accept = tvalid && tready; captures instruction and `alu_result` into stage register.
- EMPTY: accept -> FRESH.
- FRESH: !hold -> retire using bus `data_from_memory`; then accept ? FRESH : EMPTY. hold -> copy `data_from_memory` into `data_q`, -> HELD.
- HELD: !hold -> retire using `data_q`; then accept ? FRESH : EMPTY. hold -> stay.
- Writes rd for OPCODE_LOAD, OP, OP_IMM, LUI, AUIPC, JAL, JALR; rd==0 suppresses `rd_write_enable` but still retires.
- Write data: loads -> extracted value; others -> `alu_result`.
- Load extraction, offset a=`alu_result[1:0]`: LB/LBU byte a, sign/zero-extend; LH/LHU halfword a[1], extend; LW full word.
- Misaligned (LH/LHU with a[0]=1, LW with a!=0): no rd write, `misaligned_load`=1, still retires.
- Stores/branches retire with no write.
- `instret` += 1 per retire, wraps at 2^64.
- `pending_valid`/`pending_rd` reflect stage register in FRESH/HELD when instruction writes a nonzero rd.

## Timing
- Reset: state EMPTY, `data_q`=0, `instret`=0; all outputs 0 except `tready`=1.
- Latency: accept at edge N -> retire (write strobe combinational) in cycle N+1 if hold low; regfile commits at edge N+1.
- Throughput one per cycle with hold low: retire and accept in the same cycle.
- hold asserted during FRESH: SRAM data captured at that edge, never re-sampled.
- hold in EMPTY: still accepts; next cycle goes FRESH then HELD.
- `rd_write_enable`, `retire_valid`, `misaligned_load` only in FRESH/HELD with hold low.
- tvalid low after acceptance: bus data in FRESH is still the SRAM result and is used.
- `rst` mid-operation: pending instruction discarded, no write, `instret` cleared.

## Structure
- Shared package: `wb_state_t` enum (EMPTY, FRESH, HELD), `rd_writes(opcode)` function; funct3 load encodings and opcodes reuse existing package constants.
- Sub-module `load_extract`: combinational (funct3, offset, word) -> (value, misaligned).
- Top: FSM, stage register, `data_q`, counter.

## Test plan
- LW to 0x100, SRAM returns 0xDEADBEEF, rd=5, hold low -> cycle after accept: write x5=0xDEADBEEF, `instret`=1.
- LB addr 0x103, word 0x80FF_0000 -> x6=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
- LW at 0x101 -> no write, `misaligned_load`=1, `retire_valid`=1; LH at 0x103 same.
- Load accepted, hold high 3 cycles, bus data changes to 0x12345678 meanwhile -> on release writes originally captured word; `tready`=0 while HELD.
- Back-to-back ADDI x1, x2, x0-dest with hold low -> three retires in consecutive cycles, x0 never written, `instret`=3.
- `rst` asserted in FRESH -> no write that cycle, `instret`=0, state EMPTY, `tready`=1.
